cereal_tx: RTL
==============

# cereal_tx

Parametrised asynchronous serial transmitter that frames a parallel word as start bit, data bits (LSB first), optional parity bit and one or two stop bits. The line is advanced by an external one-cycle baud tick `pulse`, supplied by the baud generator. The block adds a ready/accept handshake, input capture, and a frame-complete strobe, so upstream logic can stream words back to back. It sits between the command/data path and the board-level TX pin.

## Interface
Parameters:
- `DATA_BITS`, 8, data word width; legal range 5..9.
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2.
- `PARITY_ODD`, 0, parity sense: 0 = even, 1 = odd. Only used when parity is compiled in.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pulse`  in  1  baud tick, high for one `clk` cycle per bit period.
- `data`  in  DATA_BITS  word to send; sampled only on accept.
- `start`  in  1  send request; accepted when `ready`=1.
- `ready`  out  1  high in IDLE; request may be accepted.
- `busy`  out  1  high from accept until the frame finishes.
- `done`  out  1  one-cycle strobe after the last stop bit ends.
- `cereal`  out  1  serial line; idles high.

## Operation
- FSM states: IDLE, ARM, START, DATA, PARITY (only with macro), STOP.
- IDLE: `ready`=1, `cereal`=1. When `start`=1, accept: capture `data` into the shift register, clear bit counter, go to ARM. With `start`=0, hold.
- ARM: line stays high. The next `pulse` drives `cereal`<=0 and moves to START. A `pulse` in the accept cycle itself is not counted.
- START: on `pulse`, drive bit 0 and go to DATA.
- DATA: on each `pulse`, shift and drive the next bit. When bit DATA_BITS-1 has been on the line for one period, the next `pulse` drives the parity bit (go to PARITY), or drives 1 (go to STOP).
- PARITY: on `pulse`, drive 1 and go to STOP.
- STOP: count STOP_BITS periods. On the `pulse` that ends the last one, go to IDLE and assert `done` for the following cycle. `cereal` remains 1.
- `cereal` is a register that changes only on `pulse` edges or reset. Every bit lasts exactly one pulse interval.
- `busy` = state != IDLE. `ready` = state == IDLE.
- `start` while `busy`=1 is ignored; it is not queued.
- Changes on `data` after accept do not affect the frame in flight.
- Bit counter width is ceil(log2(DATA_BITS+1)). It must not wrap within a frame.
- Unreachable state encodings return to IDLE with `cereal`=1.

## Timing
- Reset values: `cereal`=1, `busy`=0, `ready`=1, `done`=0, state IDLE. The shift register and counter are cleared.
- Reset asserted mid-frame forces the line high immediately (asynchronously). The frame is abandoned and no `done` is produced.
- Accept-to-falling-edge latency: up to one pulse interval. The edge occurs at the first `pulse` strictly after the accept cycle.
- Frame length is 1 + DATA_BITS + P + STOP_BITS pulse intervals, where P = 1 with parity and 0 without.
- `done` and `ready` both rise in the cycle after the final stop-bit `pulse`. `start` in that cycle is accepted, so back-to-back frames need no extra idle bit period.
- Simultaneous `start` and `pulse` in IDLE: the request is accepted, and that pulse does not begin the start bit.

## Configuration
- `CEREAL_TX_PARITY_EN` defined: PARITY state is present. The parity bit is XOR of the captured word for even parity, or its inverse when PARITY_ODD=1. It is sent after the data bits and before the stop bits.
- `CEREAL_TX_PARITY_EN` undefined: no PARITY state or parity logic. STOP follows the last data bit directly, and PARITY_ODD has no effect.

## Test plan
- 8N1, `pulse` every 16 clocks, send 0xA5 → line per period: 0,1,0,1,0,0,1,0,1,1. Then `done` for one cycle, and `busy` high for 10 periods plus the arm wait.
- Macro defined, 8 data bits: 0xA5 with PARITY_ODD=0 → parity bit 0; with PARITY_ODD=1 → parity bit 1. Frame is 11 periods.
- DATA_BITS=7, STOP_BITS=2, send 0x41 → line 0,1,0,0,0,0,0,1,1,1. `done` comes only after the second stop bit.
- Raise `start` with 0x3C during the DATA phase of a 0xA5 frame → ignored. Only 0xA5 is sent, and `ready` stays low until `done`.
- Drive `start` in the `done` cycle with 0xFF → accepted. The next start bit begins at the next `pulse`, with no gap beyond the arm wait.
- Drop `rst_n` during bit 3 → `cereal`=1, `busy`=0, `ready`=1 immediately, and no `done`. After release, a new 0x55 frame transmits correctly.

Source files
------------

// File: rtl/cereal_tx.sv
// cereal_tx: asynchronous serial transmitter with a ready/start handshake.
// Each frame is one start bit, DATA_BITS data bits sent LSB first, an
// optional parity bit and STOP_BITS stop bits. Every line transition is
// triggered by the external one-cycle baud tick `pulse`.
//
// Build option: define CEREAL_TX_PARITY_EN to add the parity bit. It is
// even parity, or odd parity when PARITY_ODD=1. With the macro undefined
// there is no parity state or parity logic.
//
// Parameter ranges: DATA_BITS 5..9, STOP_BITS 1 or 2.
module cereal_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pulse,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 start,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 cereal
);

  // The counter holds 0..DATA_BITS, so it never wraps within a frame.
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd5;
`ifdef CEREAL_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  logic [2:0]           state_q,  state_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic                 cereal_q, cereal_d;
  logic                 done_q,   done_d;
`ifdef CEREAL_TX_PARITY_EN
  logic                 parity_q, parity_d;
`else
  // PARITY_ODD only matters when parity is built in.
  logic                 unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // Next-state logic: the line advances only on pulse. While idle, a request
  // is accepted whatever pulse does.
  always_comb begin
    // NOTE: every signal gets a default here first, so a path that leaves it
    // unassigned holds the register value rather than inferring a latch.
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    cereal_d = cereal_q;
    done_d   = 1'b0;
`ifdef CEREAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cereal_d = 1'b1;
        if (start) begin
          shift_d = data;
          cnt_d   = '0;
`ifdef CEREAL_TX_PARITY_EN
          parity_d = (^data) ^ PARITY_ODD;
`endif
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (pulse) begin
          cereal_d = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (pulse) begin
          cereal_d = shift_q[0];
          shift_d  = shift_q >> 1;
          cnt_d    = CNT_W'(1);
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pulse) begin
          // cnt_q counts the data bits already driven onto the line.
          if (cnt_q == CNT_W'(DATA_BITS)) begin
            cnt_d = '0;
`ifdef CEREAL_TX_PARITY_EN
            cereal_d = parity_q;
            state_d  = ST_PARITY;
`else
            cereal_d = 1'b1;
            state_d  = ST_STOP;
`endif
          end else begin
            cereal_d = shift_q[0];
            shift_d  = shift_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef CEREAL_TX_PARITY_EN
      ST_PARITY: begin
        if (pulse) begin
          cereal_d = 1'b1;
          state_d  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (pulse) begin
          if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        cereal_d = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State registers. Reset drives the line high at once and abandons any
  // frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      // NOTE: the shift register and counter are cleared too. They are plain
      // flops, not a RAM, so clearing them costs nothing and gives a known
      // state after reset.
      shift_q  <= '0;
      cnt_q    <= '0;
      cereal_q <= 1'b1;
      done_q   <= 1'b0;
`ifdef CEREAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values
      // from before this edge.
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      cereal_q <= cereal_d;
      done_q   <= done_d;
`ifdef CEREAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign cereal = cereal_q;

endmodule
